// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

  localparam logic [31:0] INST_NOP         = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] PC_INC           = 32'd4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  // Word-align a byte address; every PC this stage produces ends in 2'b00.
  function automatic logic [31:0] pc_align(input logic [31:0] addr);
    return addr & ~32'h0000_0003;
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Bus bundle between fetch, instruction memory, the redirect source and decode.
interface fetch_unit_if;

  // Handshake: decode takes the head on a cycle where if_valid && if_ready,
  // unless redirect_valid is high, which squashes the head without a transfer.
  // if_valid never depends on if_ready; imem_pc is purely registered.
  logic [31:0] imem_pc;
  logic [31:0] imem_instr;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic [31:0] if_pc_plus4;

  modport master (
    output imem_pc,
    input  imem_instr,
    input  redirect_valid,
    input  redirect_target,
    output if_valid,
    input  if_ready,
    output if_instr,
    output if_pc,
    output if_pc_plus4
  );

  modport slave (
    input  imem_pc,
    output imem_instr,
    output redirect_valid,
    output redirect_target,
    input  if_valid,
    output if_ready,
    input  if_instr,
    input  if_pc,
    input  if_pc_plus4
  );

endinterface

// File: rtl/fetch_queue.sv
// Circular buffer of fetched {pc, instr} entries; flush empties it in one cycle.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push_i,
  input  fetch_entry_t               push_data_i,
  input  logic                       pop_i,
  input  logic                       flush_i,
  output fetch_entry_t               head_data_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  fetch_entry_t     mem_q [DEPTH];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush_i) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      // Pointers are log2(DEPTH) wide, so they wrap without explicit compare.
      if (push_i) tail_d = tail_q + PTR_W'(1);
      if (pop_i)  head_d = head_q + PTR_W'(1);
      case ({push_i, pop_i})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Payload storage needs no reset: the top gates every read with count != 0.
  always_ff @(posedge clk) begin
    if (push_i && !flush_i) mem_q[tail_q] <= push_data_i;
  end

  assign head_data_o = mem_q[head_q];
  assign count_o     = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: owns the PC, reads the instruction memory and feeds decode.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = DEFAULT_RESET_PC,
  parameter int          QUEUE_DEPTH = 2
) (
  input logic          clk,
  input logic          rst_n,
  fetch_unit_if.master bus
);

  localparam int CNT_W = $clog2(QUEUE_DEPTH) + 1;

  logic [31:0]      pc_q, pc_d;
  logic [CNT_W-1:0] count;
  fetch_entry_t     head;
  fetch_entry_t     push_data;
  logic             valid;
  logic             pop;
  logic             push;

  assign valid = (count != '0);
  assign pop   = valid && bus.if_ready && !bus.redirect_valid;
  // A simultaneous pop frees a slot, so a full queue still streams one per cycle.
  assign push  = !bus.redirect_valid && ((count < CNT_W'(QUEUE_DEPTH)) || pop);

  assign push_data.pc    = pc_q;
  assign push_data.instr = bus.imem_instr;

  always_comb begin
    pc_d = pc_q;
    if (bus.redirect_valid) pc_d = pc_align(bus.redirect_target);
    else if (push)          pc_d = pc_q + PC_INC;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) pc_q <= pc_align(RESET_PC);
    else        pc_q <= pc_d;
  end

  fetch_queue #(
    .DEPTH(QUEUE_DEPTH)
  ) u_queue (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (push),
    .push_data_i (push_data),
    .pop_i       (pop),
    .flush_i     (bus.redirect_valid),
    .head_data_o (head),
    .count_o     (count)
  );

  assign bus.imem_pc     = pc_q;
  assign bus.if_valid    = valid;
  assign bus.if_instr    = valid ? head.instr        : INST_NOP;
  assign bus.if_pc       = valid ? head.pc           : 32'h0;
  assign bus.if_pc_plus4 = valid ? head.pc + PC_INC  : 32'h0;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: reset, streaming, backpressure, redirect, wrap.
module tb_fetch_unit;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  fetch_unit_if bus();

  fetch_unit #(
    .RESET_PC    (32'h0000_0000),
    .QUEUE_DEPTH (2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Memory model: word k holds 32'h1000_0000 + k.
  assign bus.imem_instr = 32'h1000_0000 + (bus.imem_pc >> 2);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.redirect_valid  = 1'b0;
    bus.redirect_target = 32'h0;
    bus.if_ready        = 1'b1;
    step();
    step();
    n_cmp++; if (bus.imem_pc !== 32'h0) begin n_err++; $display("FAIL reset_imem_pc: got %h want %h", bus.imem_pc, 32'h0); end
    n_cmp++; if (bus.if_valid !== 1'b0) begin n_err++; $display("FAIL reset_if_valid: got %b want 0", bus.if_valid); end
    n_cmp++; if (bus.if_instr !== 32'h0) begin n_err++; $display("FAIL reset_if_instr: got %h want 0", bus.if_instr); end
    n_cmp++; if (bus.if_pc !== 32'h0) begin n_err++; $display("FAIL reset_if_pc: got %h want 0", bus.if_pc); end
    n_cmp++; if (bus.if_pc_plus4 !== 32'h0) begin n_err++; $display("FAIL reset_if_pc_plus4: got %h want 0", bus.if_pc_plus4); end
  endtask

  task automatic test_free_run();
    rst_n = 1'b1;
    n_cmp++; if (bus.if_valid !== 1'b0) begin n_err++; $display("FAIL release_valid: got %b want 0", bus.if_valid); end
    for (int k = 0; k < 4; k++) begin
      step();
      n_cmp++; if (bus.if_valid !== 1'b1) begin n_err++; $display("FAIL run_valid[%0d]: got %b want 1", k, bus.if_valid); end
      n_cmp++; if (bus.if_pc !== 32'(4 * k)) begin n_err++; $display("FAIL run_pc[%0d]: got %h want %h", k, bus.if_pc, 32'(4 * k)); end
      n_cmp++; if (bus.if_instr !== 32'h1000_0000 + 32'(k)) begin n_err++; $display("FAIL run_instr[%0d]: got %h want %h", k, bus.if_instr, 32'h1000_0000 + 32'(k)); end
      n_cmp++; if (bus.if_pc_plus4 !== 32'(4 * k + 4)) begin n_err++; $display("FAIL run_plus4[%0d]: got %h want %h", k, bus.if_pc_plus4, 32'(4 * k + 4)); end
      n_cmp++; if (bus.imem_pc !== 32'(4 * k + 4)) begin n_err++; $display("FAIL run_imem_pc[%0d]: got %h want %h", k, bus.imem_pc, 32'(4 * k + 4)); end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] exp_q[$];
    logic [31:0] exp_pc;
    bus.if_ready        = 1'b0;
    bus.redirect_valid  = 1'b1;
    bus.redirect_target = 32'h0;
    step();
    bus.redirect_valid = 1'b0;
    n_cmp++; if (bus.if_valid !== 1'b0) begin n_err++; $display("FAIL bp_start_valid: got %b want 0", bus.if_valid); end
    step();
    step();
    step();
    n_cmp++; if (bus.imem_pc !== 32'h8) begin n_err++; $display("FAIL bp_stall_pc: got %h want %h", bus.imem_pc, 32'h8); end
    n_cmp++; if (bus.if_pc !== 32'h0) begin n_err++; $display("FAIL bp_head_pc: got %h want 0", bus.if_pc); end
    exp_q = '{32'h0, 32'h4, 32'h8};
    bus.if_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      exp_pc = exp_q.pop_front();
      n_cmp++; if (bus.if_valid !== 1'b1 || bus.if_pc !== exp_pc) begin n_err++; $display("FAIL bp_order[%0d]: got v=%b pc=%h want v=1 pc=%h", k, bus.if_valid, bus.if_pc, exp_pc); end
      step();
      if (k == 0) begin
        n_cmp++; if (bus.imem_pc !== 32'hC) begin n_err++; $display("FAIL bp_resume_pc: got %h want %h", bus.imem_pc, 32'hC); end
      end
    end
  endtask

  task automatic test_redirect_full();
    bus.if_ready        = 1'b0;
    bus.redirect_valid  = 1'b1;
    bus.redirect_target = 32'h20;
    step();
    bus.redirect_valid = 1'b0;
    step();
    step();
    n_cmp++; if (bus.if_pc !== 32'h20 || bus.imem_pc !== 32'h28) begin n_err++; $display("FAIL rd_full: got pc=%h imem=%h want pc=20 imem=28", bus.if_pc, bus.imem_pc); end
    bus.redirect_valid  = 1'b1;
    bus.redirect_target = 32'h0000_0103;
    bus.if_ready        = 1'b1;
    step();
    bus.redirect_valid = 1'b0;
    n_cmp++; if (bus.if_valid !== 1'b0) begin n_err++; $display("FAIL rd_squash_valid: got %b want 0", bus.if_valid); end
    n_cmp++; if (bus.imem_pc !== 32'h100) begin n_err++; $display("FAIL rd_target_pc: got %h want %h", bus.imem_pc, 32'h100); end
    step();
    n_cmp++; if (bus.if_valid !== 1'b1 || bus.if_pc !== 32'h100) begin n_err++; $display("FAIL rd_head: got v=%b pc=%h want v=1 pc=100", bus.if_valid, bus.if_pc); end
    n_cmp++; if (bus.if_instr !== 32'h1000_0040) begin n_err++; $display("FAIL rd_instr: got %h want %h", bus.if_instr, 32'h1000_0040); end
    n_cmp++; if (bus.if_pc_plus4 !== 32'h104) begin n_err++; $display("FAIL rd_plus4: got %h want %h", bus.if_pc_plus4, 32'h104); end
  endtask

  task automatic test_wrap();
    bus.if_ready        = 1'b1;
    bus.redirect_valid  = 1'b1;
    bus.redirect_target = 32'hFFFF_FFFC;
    step();
    bus.redirect_valid = 1'b0;
    n_cmp++; if (bus.imem_pc !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL wrap_imem_pc: got %h want %h", bus.imem_pc, 32'hFFFF_FFFC); end
    step();
    n_cmp++; if (bus.if_pc !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL wrap_if_pc: got %h want %h", bus.if_pc, 32'hFFFF_FFFC); end
    n_cmp++; if (bus.if_pc_plus4 !== 32'h0) begin n_err++; $display("FAIL wrap_plus4: got %h want 0", bus.if_pc_plus4); end
    n_cmp++; if (bus.if_instr !== 32'h4FFF_FFFF) begin n_err++; $display("FAIL wrap_instr: got %h want %h", bus.if_instr, 32'h4FFF_FFFF); end
    n_cmp++; if (bus.imem_pc !== 32'h0) begin n_err++; $display("FAIL wrap_next_pc: got %h want 0", bus.imem_pc); end
    step();
    n_cmp++; if (bus.if_pc !== 32'h0 || bus.if_instr !== 32'h1000_0000) begin n_err++; $display("FAIL wrap_after: got pc=%h instr=%h want pc=0 instr=10000000", bus.if_pc, bus.if_instr); end
  endtask

  task automatic test_reset_mid();
    bus.if_ready = 1'b0;
    step();
    n_cmp++; if (bus.if_valid !== 1'b1) begin n_err++; $display("FAIL mid_nonempty: got %b want 1", bus.if_valid); end
    rst_n               = 1'b0;
    bus.redirect_valid  = 1'b1;
    bus.redirect_target = 32'h200;
    step();
    n_cmp++; if (bus.imem_pc !== 32'h0) begin n_err++; $display("FAIL mid_imem_pc: got %h want 0", bus.imem_pc); end
    n_cmp++; if (bus.if_valid !== 1'b0) begin n_err++; $display("FAIL mid_valid: got %b want 0", bus.if_valid); end
    n_cmp++; if (bus.if_instr !== 32'h0 || bus.if_pc !== 32'h0 || bus.if_pc_plus4 !== 32'h0) begin n_err++; $display("FAIL mid_outputs: got instr=%h pc=%h plus4=%h want all 0", bus.if_instr, bus.if_pc, bus.if_pc_plus4); end
    rst_n              = 1'b1;
    bus.redirect_valid = 1'b0;
    step();
    n_cmp++; if (bus.if_valid !== 1'b1 || bus.if_pc !== 32'h0) begin n_err++; $display("FAIL mid_restart: got v=%b pc=%h want v=1 pc=0", bus.if_valid, bus.if_pc); end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_free_run();
    test_backpressure();
    test_redirect_full();
    test_wrap();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage of the MIPS core: owns the program counter, drives the word address into the combinational instruction memory, and captures each returned instruction with its PC into a small queue. The queue is presented to decode through a valid/ready handshake. Decode or execute can redirect the stream for branches and jumps, which flushes everything already fetched.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- QUEUE_DEPTH, 2, number of fetched-instruction entries; must be a power of two, minimum 2.

Ports:
- clk, input, 1, single core clock; all state updates on the rising edge.
- rst_n, input, 1, reset; synchronous, active-low.
- imem_pc, output, 32, byte address presented to instruction memory; equals the internal PC register.
- imem_instr, input, 32, instruction word returned combinationally for imem_pc in the same cycle.
- redirect_valid, input, 1, replace the fetch stream this cycle.
- redirect_target, input, 32, new PC; bits [1:0] are ignored and forced to 00.
- if_valid, output, 1, queue head holds a valid instruction.
- if_ready, input, 1, decode accepts the head this cycle.
- if_instr, output, 32, head instruction; 0 (NOP) when if_valid=0.
- if_pc, output, 32, head PC; 0 when if_valid=0.
- if_pc_plus4, output, 32, if_pc+4 (mod 2^32); 0 when if_valid=0.

## Operation
- pop = if_valid & if_ready & ~redirect_valid.
- push = ~redirect_valid & (count < QUEUE_DEPTH | pop).
- On push:
  - {imem_pc, imem_instr} is written at the tail.
  - PC <= PC + 4, with wrap 32'hFFFF_FFFC -> 0.
- On no push, PC holds.
- Push and pop in the same cycle leave count unchanged, including when count is full; this sustains one instruction per cycle.
- On redirect_valid:
  - count, head and tail are cleared.
  - PC <= {redirect_target[31:2], 2'b00}.
  - if_ready is ignored that cycle; no pop is counted, so decode must treat the head as squashed.
  - The imem_instr presented that cycle is discarded.
- Redirect takes priority over every push and pop.
- imem_pc[1:0] is always 00.
- Reset (rst_n=0 at an edge), including mid-stream:
  - PC <= RESET_PC.
  - count, head and tail <= 0.
  - All if_* outputs read 0 in the following cycle.
  - Reset overrides redirect.
- if_* outputs are driven combinationally from the head entry, gated by if_valid.
- The block has no other state machine: the queue count (0..QUEUE_DEPTH) is the only control state.

## Timing
- Reset values: imem_pc=RESET_PC; if_valid=0; if_instr=0; if_pc=0; if_pc_plus4=0.
- Fetch latency is 1 cycle: if imem_pc=A in cycle N and push occurs, the instruction at A is at the head (if_valid=1) in cycle N+1 at the earliest.
- Redirect latency:
  - redirect_valid asserted in cycle N gives imem_pc=target in cycle N+1.
  - if_valid=0 in N+1.
  - The target instruction is at the head in N+2.
- Backpressure: with if_ready=0, the queue fills in QUEUE_DEPTH cycles, then imem_pc stalls on the next unfetched address.
- First cycle with if_ready=1 after full: pop and push together, PC advances.
- No combinational path from if_ready to imem_pc; imem_pc is purely registered.

## Structure
- Shared package/header `fetch_pkg`:
  - INST_NOP = 32'h0000_0000.
  - Default RESET_PC.
  - PC increment constant 4.
  - Queue entry layout {pc[31:0], instr[31:0]}.
- Sub-module `fetch_queue`:
  - Circular buffer of QUEUE_DEPTH entries with head/tail pointers of width log2(QUEUE_DEPTH) that wrap naturally.
  - count register of width log2(QUEUE_DEPTH)+1.
  - Ports: push, push_data, pop, flush, head_data, count.
- The top level holds the PC register, push/pop/redirect decision and output gating.

## Test plan
- Reset and free-run:
  - Stimulus: rst_n=0 for 2 cycles, RESET_PC=0, memory word k = 32'h1000_0000+k, if_ready=1.
  - Response: if_valid first high the cycle after release with if_pc=0, if_instr=32'h1000_0000; then one instruction per cycle with PC 4, 8, 12 and if_pc_plus4=if_pc+4.
- Backpressure:
  - Stimulus: hold if_ready=0 from fetch of PC 0.
  - Response: entries for PC 0 and 4 are queued and imem_pc stays at 8. Raising if_ready pops PC 0 and pushes PC 8 in the same cycle; the order 0, 4, 8 is preserved with no duplicates or drops.
- Redirect with full queue:
  - Stimulus: queue full with PC 0x20/0x24, redirect_valid=1, redirect_target=32'h0000_0103, if_ready=1 in the same cycle.
  - Response: next cycle if_valid=0 and imem_pc=0x100; the cycle after, if_pc=0x100; PC 0x20 is never counted as accepted.
- Wrap-around:
  - Stimulus: redirect to 32'hFFFF_FFFC.
  - Response: the fetched entry has if_pc=FFFF_FFFC and if_pc_plus4=0; the next fetch address is 0.
- Reset mid-stream:
  - Stimulus: rst_n=0 during a cycle that has redirect_valid=1 and a non-empty queue.
  - Response: next cycle imem_pc=RESET_PC and if_valid=0, with if_instr, if_pc and if_pc_plus4 all 0.
